// File: rtl/imm_accumulator.sv
// imm_accumulator
//   Sums bursts of N sign-extended operands into a saturating signed
//   accumulator and presents each burst result on a valid/ready output port
//   until the consumer takes it.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset, released synchronously to clk
//   clear      synchronous abort of the burst in progress (highest priority)
//   in_valid   in_data carries an operand
//   in_ready   block can accept an operand (a function of state only)
//   in_data    IN_W-bit signed operand, already sign-extended upstream
//   out_valid  out_data / out_sat / out_count hold a finished burst result
//   out_ready  consumer takes the result
//   out_data   ACC_W-bit signed burst sum, saturated
//   out_sat    the clamp was applied at least once during this burst
//   out_count  operands accepted so far in the current burst
module imm_accumulator #(
  parameter int IN_W  = 11,
  parameter int ACC_W = 16,
  parameter int N     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_sat,
  output logic [3:0]       out_count
);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  localparam int               EXT_W   = ACC_W + 1;
  localparam logic [3:0]       N_CNT   = 4'(N);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [0:0]       state_r;
  logic [0:0]       state_nxt_s;
  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] acc_nxt_s;
  logic             sat_r;
  logic             sat_nxt_s;
  logic [3:0]       count_r;
  logic [3:0]       count_nxt_s;

  logic [EXT_W-1:0] sum_s;
  logic             ovf_s;
  logic [ACC_W-1:0] clamped_s;
  logic [3:0]       count_inc_s;
  logic             accept_s;
  logic             handshake_s;

  assign accept_s    = in_valid  && (state_r == ACCUM);
  assign handshake_s = out_ready && (state_r == HOLD);
  assign count_inc_s = count_r + 4'd1;

  // Saturating add: one guard bit; overflow when the guard and the ACC_W sign bit disagree.
  always_comb begin
    sum_s = {acc_r[ACC_W-1], acc_r} + {{(EXT_W-IN_W){in_data[IN_W-1]}}, in_data};
    ovf_s = sum_s[ACC_W] ^ sum_s[ACC_W-1];
    if (ovf_s) begin
      // The guard bit holds the true sign of the unclamped sum.
      clamped_s = sum_s[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      clamped_s = sum_s[ACC_W-1:0];
    end
  end

  // Next-state logic: clear overrides any accept or handshake in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    sat_nxt_s   = sat_r;
    count_nxt_s = count_r;
    if (clear) begin
      state_nxt_s = ACCUM;
      acc_nxt_s   = {ACC_W{1'b0}};
      sat_nxt_s   = 1'b0;
      count_nxt_s = 4'd0;
    end else begin
      case (state_r)
        ACCUM: begin
          if (accept_s) begin
            acc_nxt_s   = clamped_s;
            sat_nxt_s   = sat_r | ovf_s;
            count_nxt_s = count_inc_s;
            if (count_inc_s == N_CNT) begin
              state_nxt_s = HOLD;
            end else begin
              state_nxt_s = ACCUM;
            end
          end else begin
            state_nxt_s = ACCUM;
          end
        end
        HOLD: begin
          if (handshake_s) begin
            state_nxt_s = ACCUM;
            acc_nxt_s   = {ACC_W{1'b0}};
            sat_nxt_s   = 1'b0;
            count_nxt_s = 4'd0;
          end else begin
            state_nxt_s = HOLD;
          end
        end
        default: begin
          state_nxt_s = ACCUM;
          acc_nxt_s   = {ACC_W{1'b0}};
          sat_nxt_s   = 1'b0;
          count_nxt_s = 4'd0;
        end
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ACCUM;
      acc_r   <= {ACC_W{1'b0}};
      sat_r   <= 1'b0;
      count_r <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      acc_r   <= acc_nxt_s;
      sat_r   <= sat_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  // Outputs come straight from registers; in HOLD count_r equals N.
  assign in_ready  = (state_r == ACCUM);
  assign out_valid = (state_r == HOLD);
  assign out_data  = acc_r;
  assign out_sat   = sat_r;
  assign out_count = count_r;

endmodule
